bft_inject_sched: RTL
=====================

// Module: bft_inject_sched
// PURPOSE
//  Per-client injection scheduler for the deflection BFT leaf port. Shares the single
//  leaf injection slot among NREQ local requesters using a round-robin arbiter.
//  Holds the granted packet in an output register until the leaf sees an empty slot,
//  i.e. no transiting or deflected packet occupies it that cycle.
//  Flags starvation so the switch fabric can be tuned or a client throttled.
// PARAMETERS
//  NREQ       4   number of local requesters (>=2)
//  A_W        4   packet address width; matches the router address width
//  D_W        32  packet payload width
//  STARVE_MAX 15  consecutive blocked cycles before o_starve asserts (>=1)
// PORTS
//  clk        in   1          clock
//  rst        in   1          asynchronous reset, active-high
//  ce         in   1          clock enable; low freezes all state
//  req_v      in   NREQ       requester i has a packet
//  req_addr   in   NREQ*A_W   destination address; slice i = [i*A_W +: A_W]
//  req_data   in   NREQ*D_W   payload; slice i = [i*D_W +: D_W]
//  req_rdy    out  NREQ       one-hot grant; requester i's packet is taken this cycle
//  net_busy   in   1          leaf slot is occupied this cycle; injection not allowed
//  inj_v      out  1          held packet valid toward the leaf
//  inj_addr   out  A_W        held packet address
//  inj_data   out  D_W        held packet payload
//  inj_fire   out  1          packet enters the network this cycle
//  o_starve   out  1          held packet has been blocked STARVE_MAX cycles
// BEHAVIOUR
//  Reset values (asynchronous, immediate):
//   - state=IDLE, rr_ptr=0, blk_cnt=0
//   - inj_v=0, inj_addr=0, inj_data=0, o_starve=0
//  inj_fire = inj_v & ~net_busy & ce   (combinational)
//  req_rdy  = grant vector              (combinational)
//  Grant: issued only if ce & any req_v & (state==IDLE | inj_fire).
//   - Winner = first i with req_v[i] high, searching rr_ptr, rr_ptr+1 .. NREQ-1, 0 .. (wrap).
//   - On grant: rr_ptr <= (winner+1) mod NREQ; winner's addr/data latched into inj_*.
//  FSM, two states; the state register drives inj_v:
//   - IDLE: no grant -> stay IDLE. Grant -> HOLD.
//   - HOLD: inj_fire with grant -> stay HOLD, new packet loaded (back-to-back, 1/cycle).
//   - HOLD: inj_fire without grant -> IDLE, inj_v=0. No fire -> stay HOLD, inj_* stable.
//  Latency:
//   - request to inj_v: 1 cycle.
//   - best case request to fire: 1 cycle after grant, or same cycle as grant if
//     the previous packet is firing (pipelined refill).
//  Handshake:
//   - requester keeps req_v/addr/data stable until req_rdy is seen.
//   - req_rdy is never asserted while ce=0 or while HOLD is blocked.
//  Starvation counter, blk_cnt, width $clog2(STARVE_MAX+1):
//   - HOLD & net_busy & ce: blk_cnt increments, saturating at STARVE_MAX.
//   - inj_fire, or entering HOLD with a new packet: blk_cnt <= 0.
//   - o_starve is registered: o_starve <= (next blk_cnt == STARVE_MAX).
//     It stays high while saturated and clears in the cycle after inj_fire.
//  Boundary cases:
//   - req_v withdrawn by a non-winner: no effect.
//   - Only one requester active: it is granted every opportunity. rr_ptr still
//     advances past it and the search wraps back to it.
//   - net_busy and ce both low: nothing fires; state and counters hold.
//   - rst asserted mid-HOLD: held packet is dropped; requester was already
//     acknowledged, so loss is accepted at reset.
// TESTING
//  1. Assert rst async mid-cycle while in HOLD -> inj_v, o_starve fall immediately;
//     after release, first grant goes to req 0 (rr_ptr=0).
//  2. req_v=4'b0100, addr=4'h5, data=32'hDEADBEEF, net_busy=0 ->
//     cycle0: req_rdy=4'b0100; cycle1: inj_v=1, inj_addr=5, inj_fire=1.
//  3. req_v=4'b1111 held continuously, net_busy=0 -> grants 0,1,2,3,0,1,
//     one per cycle; inj_fire high every cycle from cycle1.
//  4. One packet held, net_busy=1 for 20 cycles, STARVE_MAX=15 ->
//     o_starve rises after 15 blocked cycles; clears 1 cycle after net_busy drops and fire.
//  5. ce=0 for 5 cycles with req_v=4'b0011 in IDLE -> no req_rdy, no state change;
//     ce=1 -> grant to req 0.
//  6. HOLD, req_v=4'b1000, net_busy=1 -> no req_rdy until net_busy=0;
//     then fire and grant req 3 in the same cycle.

Source files
------------

// File: rtl/bft_inject_sched_if.sv
// Leaf-port injection bundle: requester side plus the held-packet view toward the leaf.
// Handshake: requester i holds req_v/addr/data stable until it sees req_rdy[i] high at a
// clock edge; req_rdy is a one-hot take and the packet moves into the held register there.
interface bft_inject_sched_if #(
  parameter int NREQ = 4,
  parameter int A_W  = 4,
  parameter int D_W  = 32
) ();
  logic [NREQ-1:0]     req_v;
  logic [NREQ*A_W-1:0] req_addr;
  logic [NREQ*D_W-1:0] req_data;
  logic [NREQ-1:0]     req_rdy;
  logic                net_busy;
  logic                inj_v;
  logic [A_W-1:0]      inj_addr;
  logic [D_W-1:0]      inj_data;
  logic                inj_fire;
  logic                o_starve;

  modport master (
    output req_v, req_addr, req_data, net_busy,
    input  req_rdy, inj_v, inj_addr, inj_data, inj_fire, o_starve
  );

  modport slave (
    input  req_v, req_addr, req_data, net_busy,
    output req_rdy, inj_v, inj_addr, inj_data, inj_fire, o_starve
  );
endinterface

// File: rtl/bft_inject_sched.sv
// Round-robin injection scheduler for one deflection-BFT leaf slot: grants a requester,
// holds its packet until the slot is free, and flags long blocking as starvation.
module bft_inject_sched #(
  parameter int NREQ       = 4,
  parameter int A_W        = 4,
  parameter int D_W        = 32,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  bft_inject_sched_if.slave bus,
  output logic              dbg_state_o
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             starve_q, starve_d;
  logic [A_W-1:0]   addr_q, addr_d;
  logic [D_W-1:0]   data_q, data_d;

  logic             fire;
  logic             grant_en;
  logic             found;
  logic [PTR_W-1:0] winner;
  logic [NREQ-1:0]  grant;
  int               idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      blk_cnt_q <= '0;
      starve_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      blk_cnt_q <= blk_cnt_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  // Search order starts at rr_ptr and wraps, so the last winner is visited last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req_v[idx[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    blk_cnt_d = blk_cnt_q;
    starve_d  = starve_q;
    addr_d    = addr_q;
    data_d    = data_q;
    if (ce) begin
      if (grant_en) begin
        state_d   = HOLD;
        rr_ptr_d  = (winner == PTR_LAST) ? '0 : winner + 1'b1;
        addr_d    = bus.req_addr[int'(winner)*A_W +: A_W];
        data_d    = bus.req_data[int'(winner)*D_W +: D_W];
        blk_cnt_d = '0;
      end else if (fire) begin
        state_d   = IDLE;
        blk_cnt_d = '0;
      end else if (state_q == HOLD && bus.net_busy && blk_cnt_q != CNT_MAX) begin
        blk_cnt_d = blk_cnt_q + 1'b1;
      end
      starve_d = (blk_cnt_d == CNT_MAX);
    end
  end

  // A firing packet frees the register this cycle, so a refill can be granted alongside.
  always_comb begin
    fire     = (state_q == HOLD) && !bus.net_busy && ce;
    grant_en = ce && found && ((state_q == IDLE) || fire);
    grant    = grant_en ? (NREQ'(1) << winner) : '0;
  end

  assign bus.req_rdy  = grant;
  assign bus.inj_fire = fire;
  assign bus.inj_v    = (state_q == HOLD);
  assign bus.inj_addr = addr_q;
  assign bus.inj_data = data_q;
  assign bus.o_starve = starve_q;
  assign dbg_state_o  = state_q;
endmodule
